// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: parametrised synchronous FIFO with storage, occupancy flags and op-state register.
// Defining FIFO_SCLR_EN adds a synchronous clear input (sclr) that has priority over requests.
module fifo_ctrl_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FIFO_SCLR_EN
  input  logic                  sclr,
`endif
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [2:0]            state,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_INIT   = 3'b000,
    S_WRITE  = 3'b001,
    S_WR_ERR = 3'b010,
    S_NO_OP  = 3'b011,
    S_READ   = 3'b100,
    S_RD_ERR = 3'b101,
    S_RDWR   = 3'b110
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic do_wr, do_rd;

  always_comb begin
    state_d  = S_NO_OP;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;

    case (state_q)
      S_INIT: state_d = S_NO_OP;
      S_WRITE, S_WR_ERR, S_NO_OP, S_READ, S_RD_ERR, S_RDWR: begin
        case ({wr_en, rd_en})
          2'b10: begin
            if (count_q < DEPTH_C) begin
              do_wr = 1'b1; state_d = S_WRITE; wr_ack_d = 1'b1;
            end else begin
              state_d = S_WR_ERR; wr_err_d = 1'b1;
            end
          end
          2'b01: begin
            if (count_q != '0) begin
              do_rd = 1'b1; state_d = S_READ; rd_ack_d = 1'b1;
            end else begin
              state_d = S_RD_ERR; rd_err_d = 1'b1;
            end
          end
          2'b11: begin
            // A full FIFO still accepts the write: the read frees a slot on the same edge.
            if (count_q != '0) begin
              do_wr = 1'b1; do_rd = 1'b1; state_d = S_RDWR;
              wr_ack_d = 1'b1; rd_ack_d = 1'b1;
            end else begin
              do_wr = 1'b1; state_d = S_WRITE;
              wr_ack_d = 1'b1; rd_err_d = 1'b1;
            end
          end
          default: state_d = S_NO_OP;
        endcase
      end
      default: state_d = S_INIT;
    endcase

    head_d  = do_rd ? head_q + PTR_ONE : head_q;
    tail_d  = do_wr ? tail_q + PTR_ONE : tail_q;
    dout_d  = do_rd ? mem_q[head_q] : dout_q;
    count_d = count_q;
    if (do_wr && !do_rd) count_d = count_q + CNT_ONE;
    if (do_rd && !do_wr) count_d = count_q - CNT_ONE;

`ifdef FIFO_SCLR_EN
    if (sclr) begin
      do_wr    = 1'b0;
      state_d  = S_INIT;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      dout_d   = dout_q;
      wr_ack_d = 1'b0;
      wr_err_d = 1'b0;
      rd_ack_d = 1'b0;
      rd_err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[tail_q] <= din;
  end

  assign dout         = dout_q;
  assign state        = state_q;
  assign data_count   = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign rd_ack       = rd_ack_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Scoreboard bench for fifo_ctrl_param: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fifo_ctrl_param;

  localparam logic [2:0] ST_INIT = 3'd0, ST_WRITE = 3'd1, ST_WR_ERR = 3'd2,
                         ST_NO_OP = 3'd3, ST_READ = 3'd4, ST_RD_ERR = 3'd5, ST_RDWR = 3'd6;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclr_i = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] din = '0, dout;
  logic [2:0]  state;
  logic [3:0]  data_count;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;

  fifo_ctrl_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .reset(reset),
`ifdef FIFO_SCLR_EN
    .sclr(sclr_i),
`endif
    .wr_en(wr_en), .rd_en(rd_en), .din(din), .dout(dout), .state(state),
    .data_count(data_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] dout;
    int unsigned cnt;
    logic wa, we, ra, re;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mq[$];
  logic [31:0] dout_m = '0;
  bit          m_init = 1'b1;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input exp_t e);
    chk("state", 32'(state), 32'(e.st));
    chk("dout", dout, e.dout);
    chk("data_count", 32'(data_count), e.cnt);
    chk("full", 32'(full), 32'(e.cnt == DEPTH));
    chk("empty", 32'(empty), 32'(e.cnt == 0));
    chk("almost_full", 32'(almost_full), 32'(e.cnt >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(e.cnt <= 2));
    chk("wr_ack", 32'(wr_ack), 32'(e.wa));
    chk("wr_err", 32'(wr_err), 32'(e.we));
    chk("rd_ack", 32'(rd_ack), 32'(e.ra));
    chk("rd_err", 32'(rd_err), 32'(e.re));
  endtask

  // Monitor: outputs settle after each rising edge; compare at the falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) chk_outputs(sbq.pop_front());
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic w, input logic r, input logic [31:0] d, input logic s);
    exp_t e;
    wr_en = w; rd_en = r; din = d; sclr_i = s;
    @(posedge clk);
    e.st = ST_NO_OP; e.wa = 0; e.we = 0; e.ra = 0; e.re = 0;
    if (s) begin
      m_init = 1'b1; mq.delete(); e.st = ST_INIT;
    end else if (m_init) begin
      m_init = 1'b0; e.st = ST_NO_OP;
    end else if (w && !r) begin
      if (mq.size() < DEPTH) begin mq.push_back(d); e.st = ST_WRITE; e.wa = 1; end
      else begin e.st = ST_WR_ERR; e.we = 1; end
    end else if (r && !w) begin
      if (mq.size() > 0) begin dout_m = mq.pop_front(); e.st = ST_READ; e.ra = 1; end
      else begin e.st = ST_RD_ERR; e.re = 1; end
    end else if (r && w) begin
      if (mq.size() > 0) begin
        dout_m = mq.pop_front(); mq.push_back(d); e.st = ST_RDWR; e.wa = 1; e.ra = 1;
      end else begin
        mq.push_back(d); e.st = ST_WRITE; e.wa = 1; e.re = 1;
      end
    end
    e.dout = dout_m;
    e.cnt  = mq.size();
    sbq.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that it takes effect without a clock edge.
  task automatic apply_reset();
    exp_t e;
    wr_en = 0; rd_en = 0; sclr_i = 0;
    #2 reset = 1'b1;
    #1;
    mq.delete(); m_init = 1'b1; dout_m = '0;
    e.st = ST_INIT; e.dout = '0; e.cnt = 0; e.wa = 0; e.we = 0; e.ra = 0; e.re = 0;
    chk_outputs(e);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned wp;
    logic s;
    @(negedge clk);
    apply_reset();
    step(0, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 32'hA0 + 32'(i), 0);
    step(1, 0, 32'hFF, 0);
    step(1, 1, 32'hB0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(1, 1, 32'h55, 0);
    step(0, 1, '0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 32'hC0 + 32'(i), 0);
    apply_reset();
    step(0, 0, '0, 0);
`ifdef FIFO_SCLR_EN
    for (int i = 0; i < 4; i++) step(1, 0, 32'hD0 + 32'(i), 0);
    step(1, 0, 32'hEE, 1);
    step(0, 0, '0, 0);
    step(0, 1, '0, 0);
`endif
    for (int ph = 0; ph < 8; ph++) begin
      wp = (ph % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 149) == 0) apply_reset();
        s = 1'b0;
`ifdef FIFO_SCLR_EN
        s = ($urandom_range(0, 59) == 0);
`endif
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp, $urandom, s);
      end
    end
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
